// File: rtl/actor_responder_pkg.sv
// Types shared by the launch trigger and the actor responder: the outcome codes
// reported on ap_return and the responder FSM state encoding.
package actor_responder_pkg;

    localparam logic [31:0] EXECUTED    = 32'd1;
    localparam logic [31:0] WAIT_INPUT  = 32'd2;
    localparam logic [31:0] WAIT_OUTPUT = 32'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        FIRE = 2'd2,
        DONE = 2'd3
    } responder_state_t;

    // Outcome of an invocation that left FIRE because a move was blocked.
    // An empty input outranks a full output when both block.
    function automatic logic [31:0] blocked_code(input logic moved_any,
                                                 input logic in_not_empty);
        if (moved_any)
            return EXECUTED;
        else if (!in_not_empty)
            return WAIT_INPUT;
        else
            return WAIT_OUTPUT;
    endfunction

endpackage

// File: rtl/actor_responder_stats.sv
// Saturating token / invocation counters for the actor responder.
// Only instantiated when ACTOR_RESPONDER_STATS_EN is defined.
module actor_responder_stats (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        token_moved,
    input  logic        invocation_done,
    output logic [31:0] stat_tokens,
    output logic [31:0] stat_invocations
);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            stat_tokens      <= '0;
            stat_invocations <= '0;
        end else begin
            if (token_moved && (stat_tokens != 32'hFFFF_FFFF))
                stat_tokens <= stat_tokens + 32'd1;
            if (invocation_done && (stat_invocations != 32'hFFFF_FFFF))
                stat_invocations <= stat_invocations + 32'd1;
        end
    end

endmodule

// File: rtl/actor_responder.sv
// Actor side of the trigger launch handshake: moves up to MAX_FIRINGS tokens per
// ap_start and reports the outcome. Optional stats ports: ACTOR_RESPONDER_STATS_EN.
//
// Handshake: ap_start is sampled only in IDLE; ap_done and ap_ready pulse together for
// one cycle in DONE. A token moves in any FIRE cycle where in_empty_n & out_full_n,
// with in_read and out_write asserted together in that same cycle.
module actor_responder
    import actor_responder_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MAX_FIRINGS = 16,
    parameter logic [DATA_WIDTH-1:0] OFFSET      = '0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic [31:0]           ap_return,
    output logic                  launch_predicate,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty_n,
    output logic                  in_read,
    output logic [DATA_WIDTH-1:0] out_din,
    input  logic                  out_full_n,
    output logic                  out_write,
    output logic [1:0]            debug_state
`ifdef ACTOR_RESPONDER_STATS_EN
   ,output logic [31:0]           stat_tokens,
    output logic [31:0]           stat_invocations
`endif
);

    localparam int CNT_W = $clog2(MAX_FIRINGS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_FIRINGS - 1);

    responder_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      ret_q, ret_d;
    logic             move;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ret_d   = ret_q;
        move    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    state_d = EVAL;
                    cnt_d   = '0;
                end
            end
            EVAL: state_d = FIRE;
            FIRE: begin
                move = in_empty_n & out_full_n;
                if (move) begin
                    // The counter stops at MAX_FIRINGS, so it can never wrap.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                        ret_d   = EXECUTED;
                    end
                end else begin
                    state_d = DONE;
                    ret_d   = blocked_code(cnt_q != '0, in_empty_n);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced to their reset values while ap_rst is high so a reset
    // landing mid-FIRE never pops or pushes a token.
    assign in_read          = move & ~ap_rst;
    assign out_write        = move & ~ap_rst;
    assign out_din          = in_dout + OFFSET;
    assign ap_done          = (state_q == DONE) & ~ap_rst;
    assign ap_ready         = ap_done;
    assign ap_idle          = (state_q == IDLE) | ap_rst;
    assign ap_return        = ap_rst ? 32'd0 : ret_q;
    assign launch_predicate = in_empty_n & out_full_n;
    assign debug_state      = state_q;

`ifdef ACTOR_RESPONDER_STATS_EN
    actor_responder_stats u_stats (
        .ap_clk           (ap_clk),
        .ap_rst           (ap_rst),
        .token_moved      (out_write),
        .invocation_done  (ap_done),
        .stat_tokens      (stat_tokens),
        .stat_invocations (stat_invocations)
    );
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_actor_responder.sv
// Directed bench for actor_responder: vector table of whole invocations plus
// hand-written reset, start-during-DONE and mid-FIRE reset sequences.
module tb_actor_responder;
    import actor_responder_pkg::*;

    localparam int          DW  = 32;
    localparam int          MF  = 16;
    localparam logic [31:0] OFF = 32'd5;

    logic          ap_clk = 1'b0;
    logic          ap_rst, ap_start;
    logic          ap_done, ap_ready, ap_idle, launch_predicate;
    logic [31:0]   ap_return;
    logic [DW-1:0] in_dout, out_din;
    logic          in_empty_n, in_read, out_full_n, out_write;
    logic [1:0]    debug_state;
`ifdef ACTOR_RESPONDER_STATS_EN
    logic [31:0]   stat_tokens, stat_invocations;
`endif

    always #5 ap_clk = ~ap_clk;

    actor_responder #(.DATA_WIDTH(DW), .MAX_FIRINGS(MF), .OFFSET(OFF)) dut (
        .ap_clk           (ap_clk),
        .ap_rst           (ap_rst),
        .ap_start         (ap_start),
        .ap_done          (ap_done),
        .ap_ready         (ap_ready),
        .ap_idle          (ap_idle),
        .ap_return        (ap_return),
        .launch_predicate (launch_predicate),
        .in_dout          (in_dout),
        .in_empty_n       (in_empty_n),
        .in_read          (in_read),
        .out_din          (out_din),
        .out_full_n       (out_full_n),
        .out_write        (out_write),
        .debug_state      (debug_state)
`ifdef ACTOR_RESPONDER_STATS_EN
       ,.stat_tokens      (stat_tokens),
        .stat_invocations (stat_invocations)
`endif
    );

    int checks = 0;
    int errors = 0;

    // FIFO models: source memory with read pointer, sink with write count/limit.
    logic [DW-1:0] src_mem [0:31];
    int            src_rd = 0, src_cnt = 0, wr_cnt = 0, out_limit = 0;
    int            pair_viol = 0;
    logic          rd_pend = 1'b0, wr_pend = 1'b0;
    logic [DW-1:0] exp_q [$];

    assign in_empty_n = (src_rd < src_cnt);
    assign in_dout    = src_mem[src_rd[4:0]];
    assign out_full_n = (wr_cnt < out_limit);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    // Sample DUT FIFO strobes mid-cycle, apply pointer moves on the clock edge.
    always @(negedge ap_clk) begin
        #2;
        rd_pend = in_read;
        wr_pend = out_write;
        if (in_read !== out_write) pair_viol++;
        if (out_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", out_din, 32'hFFFF_FFFF);
            end else begin
                check("out_din", out_din, exp_q.pop_front());
            end
        end
    end

    always @(posedge ap_clk) begin
        if (rd_pend) src_rd <= src_rd + 1;
        if (wr_pend) wr_cnt <= wr_cnt + 1;
    end

    typedef struct {
        int          n_tokens;
        logic [31:0] base;
        int          limit;
        int          exp_writes;
        logic [31:0] exp_ret;
        int          exp_lat;
        int          exp_left;
    } vec_t;

    vec_t vecs [7];

    task automatic load_fifos(input int n, input logic [31:0] base, input int limit);
        for (int i = 0; i < 32; i++) src_mem[i] = base + 32'(i);
        src_rd    = 0;
        src_cnt   = n;
        wr_cnt    = 0;
        out_limit = limit;
    endtask

    // Called at negedge+1; pulses ap_start and returns cycles until ap_done seen.
    task automatic launch_and_wait(output int lat, output int idle_bad);
        lat      = 0;
        idle_bad = 0;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1 ap_start = 1'b0;
        while (lat < 60) begin
            @(negedge ap_clk);
            #1;
            lat++;
            if (ap_done === 1'b1) break;
            if (ap_idle !== 1'b0) idle_bad++;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat, idle_bad;
        load_fifos(v.n_tokens, v.base, v.limit);
        for (int i = 0; i < v.exp_writes; i++) exp_q.push_back(v.base + 32'(i) + OFF);
        #1;
        check($sformatf("v%0d_predicate", idx), {31'd0, launch_predicate},
              {31'd0, (v.n_tokens > 0) && (v.limit > 0)});
        launch_and_wait(lat, idle_bad);
        check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d_ready", idx), {31'd0, ap_ready}, 32'd1);
        check($sformatf("v%0d_return", idx), ap_return, v.exp_ret);
        check($sformatf("v%0d_idle_low", idx), idle_bad, 0);
        check($sformatf("v%0d_writes", idx), wr_cnt, v.exp_writes);
        check($sformatf("v%0d_left", idx), src_cnt - src_rd, v.exp_left);
        check($sformatf("v%0d_exp_drained", idx), exp_q.size(), 0);
        @(negedge ap_clk);
        #1;
        check($sformatf("v%0d_idle_after", idx), {31'd0, ap_idle}, 32'd1);
        check($sformatf("v%0d_done_pulse", idx), {31'd0, ap_done}, 32'd0);
        check($sformatf("v%0d_return_hold", idx), ap_return, v.exp_ret);
        exp_q.delete();
    endtask

    initial begin
        int lat, idle_bad, tot_tokens, tot_inv, budget;

        vecs[0] = '{20, 32'd0,          100, 16, EXECUTED,    18, 4};
        vecs[1] = '{0,  32'd0,          100, 0,  WAIT_INPUT,  3,  0};
        vecs[2] = '{5,  32'd100,        3,   3,  EXECUTED,    6,  2};
        vecs[3] = '{5,  32'd200,        0,   0,  WAIT_OUTPUT, 3,  5};
        vecs[4] = '{0,  32'd0,          0,   0,  WAIT_INPUT,  3,  0};
        vecs[5] = '{16, 32'hFFFF_FFF0,  100, 16, EXECUTED,    18, 0};
        vecs[6] = '{1,  32'd7,          100, 1,  EXECUTED,    4,  0};

        // Reset then idle.
        ap_rst   = 1'b1;
        ap_start = 1'b0;
        load_fifos(0, 32'd0, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge ap_clk);
            if (c == 3) ap_rst = 1'b0;
            #1;
            check("rst_idle", {31'd0, ap_idle}, 32'd1);
            check("rst_done", {31'd0, ap_done}, 32'd0);
            check("rst_read", {31'd0, in_read}, 32'd0);
            check("rst_return", ap_return, 32'd0);
        end
        check("rst_state", {30'd0, debug_state}, {30'd0, IDLE});
`ifdef ACTOR_RESPONDER_STATS_EN
        check("rst_stat_tokens", stat_tokens, 32'd0);
        check("rst_stat_inv", stat_invocations, 32'd0);
`endif

        tot_tokens = 0;
        tot_inv    = 0;
        foreach (vecs[i]) begin
            run_vec(i, vecs[i]);
            tot_tokens += vecs[i].exp_writes;
            tot_inv++;
        end
`ifdef ACTOR_RESPONDER_STATS_EN
        check("stat_tokens", stat_tokens, 32'(tot_tokens));
        check("stat_inv", stat_invocations, 32'(tot_inv));
`endif

        // ap_start held through DONE: ignored there, accepted in the following IDLE.
        load_fifos(0, 32'd0, 100);
        ap_start = 1'b1;
        budget   = 0;
        while (ap_done !== 1'b1 && budget < 20) begin
            @(negedge ap_clk);
            #1;
            budget++;
        end
        check("hold_first_lat", budget, 3);
        @(negedge ap_clk);
        #1;
        check("hold_idle_after_done", {31'd0, ap_idle}, 32'd1);
        check("hold_return", ap_return, WAIT_INPUT);
        @(negedge ap_clk);
        #1;
        ap_start = 1'b0;
        check("hold_restart_eval", {31'd0, ap_idle}, 32'd0);
        @(negedge ap_clk);
        @(negedge ap_clk);
        #1;
        check("hold_second_done", {31'd0, ap_done}, 32'd1);
        @(negedge ap_clk);
        #1;

        // Reset after four tokens have moved.
        load_fifos(10, 32'd50, 100);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'd50 + 32'(i) + OFF);
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1 ap_start = 1'b0;
        budget = 0;
        while (wr_cnt < 4 && budget < 30) begin
            @(negedge ap_clk);
            #1;
            budget++;
        end
        check("midrst_reached", {31'd0, wr_cnt == 4}, 32'd1);
        ap_rst = 1'b1;
        #1;
        check("midrst_read", {31'd0, in_read}, 32'd0);
        check("midrst_write", {31'd0, out_write}, 32'd0);
        check("midrst_done", {31'd0, ap_done}, 32'd0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        check("midrst_idle", {31'd0, ap_idle}, 32'd1);
        check("midrst_done_after", {31'd0, ap_done}, 32'd0);
        check("midrst_return", ap_return, 32'd0);
        check("midrst_state", {30'd0, debug_state}, {30'd0, IDLE});
`ifdef ACTOR_RESPONDER_STATS_EN
        check("midrst_stat_tokens", stat_tokens, 32'd0);
        check("midrst_stat_inv", stat_invocations, 32'd0);
`endif
        @(negedge ap_clk);
        #3;
        check("midrst_writes", wr_cnt, 4);
        check("midrst_exp_drained", exp_q.size(), 0);
        check("midrst_no_done", {31'd0, ap_done}, 32'd0);

        check("read_write_paired", pair_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
